round_sequencer: RTL and testbench



---
 rtl/halli_pkg.sv | 21 ++
 rtl/bell_arbiter.sv | 26 ++
 rtl/round_sequencer.sv | 121 ++++++++++++
 tb/tb_round_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/halli_pkg.sv
// halli_pkg: shared state encoding, player encoding and default sizing for the Halli Galli game flow.
package halli_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_FLIP = 3'd1,
        DEAL      = 3'd2,
        BELL_WIN  = 3'd3,
        JUDGE     = 3'd4,
        OVER      = 3'd5
    } state_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } player_t;

    localparam int DECK_SIZE_DEF   = 56;
    localparam int BELL_WINDOW_DEF = 25_000_000;

endpackage

// File: rtl/bell_arbiter.sv
// bell_arbiter: picks the bell winner; simultaneous presses go to prio, which rotates only on granted ties.
module bell_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic bell1_i,
    input  logic bell2_i,
    input  logic grant_i,
    output logic winner_o,
    output logic any_o
);

    logic prio_q, prio_d;

    always_comb begin
        any_o    = bell1_i | bell2_i;
        winner_o = (bell1_i & bell2_i) ? prio_q : bell2_i;
        prio_d   = clr_i ? 1'b0 : (grant_i & bell1_i & bell2_i) ? ~prio_q : prio_q;
    end

    always_ff @(posedge clk) begin
        if (rst) prio_q <= 1'b0;
        else     prio_q <= prio_d;
    end

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: sequences turns, card deals and bell windows, and issues one award per accepted bell.
module round_sequencer
    import halli_pkg::*;
#(
    parameter int DECK_SIZE   = DECK_SIZE_DEF,
    parameter int BELL_WINDOW = BELL_WINDOW_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       flip1,
    input  logic       flip2,
    input  logic       bell1,
    input  logic       bell2,
    input  logic       match,
    output logic       deal_en,
    output logic       turn,
    output logic       award_valid,
    output logic       award_player,
    output logic       award_correct,
    output logic       clear_table,
    output logic       game_over,
    output logic [2:0] state
);

    localparam int CW = $clog2(DECK_SIZE + 1);
    localparam int TW = (BELL_WINDOW > 1) ? $clog2(BELL_WINDOW) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cards_q, cards_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            turn_q, turn_d;
    logic            deal_en_q, deal_en_d;
    logic            award_valid_q, award_valid_d;
    logic            award_player_q, award_player_d;
    logic            award_correct_q, award_correct_d;
    logic            clear_table_q, clear_table_d;
    logic            game_over_q, game_over_d;
    logic            winner, any_bell;
    logic            bell_ok, flip_ok, start_ok, timeout, deck_done;

    bell_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_ok),
        .bell1_i (bell1),
        .bell2_i (bell2),
        .grant_i (bell_ok),
        .winner_o(winner),
        .any_o   (any_bell)
    );

    // Bells are only heard while waiting for a flip or inside the window; anything else drops them.
    always_comb begin
        bell_ok   = any_bell & (state_q == WAIT_FLIP || state_q == BELL_WIN);
        flip_ok   = (state_q == WAIT_FLIP) & (turn_q ? flip2 : flip1);
        start_ok  = start & (state_q == IDLE || state_q == OVER);
        timeout   = timer_q == TW'(BELL_WINDOW - 1);
        deck_done = cards_q == CW'(DECK_SIZE);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, OVER: state_d = start ? WAIT_FLIP : state_q;
            WAIT_FLIP:  state_d = bell_ok ? JUDGE : flip_ok ? DEAL : WAIT_FLIP;
            DEAL:       state_d = BELL_WIN;
            BELL_WIN:   state_d = bell_ok ? JUDGE : !timeout ? BELL_WIN : deck_done ? OVER : WAIT_FLIP;
            JUDGE:      state_d = deck_done ? OVER : WAIT_FLIP;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cards_d         = start_ok ? '0 : (state_q == DEAL && !deck_done) ? cards_q + CW'(1) : cards_q;
        turn_d          = start_ok ? 1'b0 : (state_q == DEAL) ? ~turn_q : turn_q;
        timer_d         = (state_q == BELL_WIN && state_d == BELL_WIN) ? timer_q + TW'(1) : '0;
        deal_en_d       = state_d == DEAL;
        award_valid_d   = state_d == JUDGE;
        award_player_d  = award_valid_d ? winner : award_player_q;
        award_correct_d = award_valid_d ? match : award_correct_q;
        clear_table_d   = award_valid_d & match;
        game_over_d     = state_d == OVER;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cards_q         <= '0;
            timer_q         <= '0;
            turn_q          <= 1'b0;
            deal_en_q       <= 1'b0;
            award_valid_q   <= 1'b0;
            award_player_q  <= 1'b0;
            award_correct_q <= 1'b0;
            clear_table_q   <= 1'b0;
            game_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cards_q         <= cards_d;
            timer_q         <= timer_d;
            turn_q          <= turn_d;
            deal_en_q       <= deal_en_d;
            award_valid_q   <= award_valid_d;
            award_player_q  <= award_player_d;
            award_correct_q <= award_correct_d;
            clear_table_q   <= clear_table_d;
            game_over_q     <= game_over_d;
        end
    end

    assign deal_en       = deal_en_q;
    assign turn          = turn_q;
    assign award_valid   = award_valid_q;
    assign award_player  = award_player_q;
    assign award_correct = award_correct_q;
    assign clear_table   = clear_table_q;
    assign game_over     = game_over_q;
    assign state         = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed game scenarios; expected deal/award strobes are queued and checked by a monitor.
module tb_round_sequencer;
    import halli_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, flip1 = 1'b0, flip2 = 1'b0, bell1 = 1'b0, bell2 = 1'b0, match = 1'b0;
    logic deal_en, turn, award_valid, award_player, award_correct, clear_table, game_over;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic aw;
        logic pl;
        logic co;
        logic cl;
    } ev_t;
    ev_t exp_q[$];

    round_sequencer #(.DECK_SIZE(3), .BELL_WINDOW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .flip1(flip1), .flip2(flip2),
        .bell1(bell1), .bell2(bell2), .match(match), .deal_en(deal_en), .turn(turn),
        .award_valid(award_valid), .award_player(award_player), .award_correct(award_correct),
        .clear_table(clear_table), .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: every deal/award strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (deal_en || award_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got deal_en=%0b award_valid=%0b, required none", deal_en, award_valid);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.aw && !(award_valid && !deal_en && award_player == e.pl &&
                              award_correct == e.co && clear_table == e.cl)) begin
                    errors++;
                    $display("FAIL award: got v=%0b d=%0b pl=%0b co=%0b cl=%0b, required v=1 d=0 pl=%0b co=%0b cl=%0b",
                             award_valid, deal_en, award_player, award_correct, clear_table, e.pl, e.co, e.cl);
                end
                if (!e.aw && !(deal_en && !award_valid && turn == e.pl)) begin
                    errors++;
                    $display("FAIL deal: got d=%0b v=%0b turn=%0b, required d=1 v=0 turn=%0b",
                             deal_en, award_valid, turn, e.pl);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic cyc(input logic s, input logic f1, input logic f2, input logic b1, input logic b2);
        start = s; flip1 = f1; flip2 = f2; bell1 = b1; bell2 = b2;
        @(negedge clk);
        start = 1'b0; flip1 = 1'b0; flip2 = 1'b0; bell1 = 1'b0; bell2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic exp_deal(input logic p);
        exp_q.push_back('{aw: 1'b0, pl: p, co: 1'b0, cl: 1'b0});
    endtask

    task automatic exp_award(input logic p, input logic co);
        exp_q.push_back('{aw: 1'b1, pl: p, co: co, cl: co});
    endtask

    // Deal by player p, then let the whole window time out.
    task automatic deal_timeout(input logic p, input logic [2:0] after);
        exp_deal(p);
        cyc(0, !p, p, 0, 0);
        idle(5);
        chk("state_after_window", state, after);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", state, 3'(IDLE));
        chk("reset_outputs", {1'b0, deal_en, turn, award_valid, award_player, award_correct, clear_table, game_over}, 8'h00);
        rst = 1'b0;
        cyc(1, 0, 0, 0, 0);
        chk("start_to_wait", state, 3'(WAIT_FLIP));

        exp_deal(0);
        cyc(0, 1, 0, 0, 0);
        chk("flip1_deal_state", state, 3'(DEAL));
        idle(1);
        chk("bellwin_entry", state, 3'(BELL_WIN));
        chk("turn_after_deal", turn, 1);
        for (int i = 1; i < 4; i++) begin
            idle(1);
            chk("bellwin_hold", state, 3'(BELL_WIN));
        end
        idle(1);
        chk("window_timeout", state, 3'(WAIT_FLIP));

        cyc(0, 1, 0, 0, 0);
        chk("wrong_player_flip", state, 3'(WAIT_FLIP));
        exp_deal(1);
        cyc(0, 0, 1, 0, 0);
        idle(1);
        chk("turn_back_to_p1", turn, 0);

        match = 1'b1;
        exp_award(1, 1);
        cyc(0, 0, 0, 0, 1);
        chk("judge_state", state, 3'(JUDGE));
        idle(1);
        chk("judge_to_wait", state, 3'(WAIT_FLIP));
        chk("award_hold", {5'd0, award_valid, award_player, award_correct}, 8'h03);
        chk("clear_strobe_off", clear_table, 0);

        exp_deal(0);
        cyc(0, 1, 0, 0, 0);
        idle(1);
        match = 1'b0;
        exp_award(1, 0);
        cyc(0, 0, 0, 0, 1);
        idle(1);
        chk("judge_last_card_over", state, 3'(OVER));
        chk("game_over_level", game_over, 1);
        cyc(1, 0, 0, 0, 0);
        chk("restart_wait", state, 3'(WAIT_FLIP));
        chk("restart_turn", turn, 0);

        exp_award(0, 0);
        cyc(0, 0, 0, 1, 1);
        idle(1);
        exp_award(1, 0);
        cyc(0, 0, 0, 1, 1);
        idle(1);
        exp_award(0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
        chk("bell_in_judge_dropped", state, 3'(WAIT_FLIP));
        exp_award(0, 0);
        cyc(0, 0, 0, 1, 1);
        idle(1);
        exp_award(0, 0);
        cyc(0, 1, 0, 1, 0);
        chk("bell_beats_flip", state, 3'(JUDGE));
        idle(1);

        deal_timeout(0, 3'(WAIT_FLIP));
        deal_timeout(1, 3'(WAIT_FLIP));
        deal_timeout(0, 3'(OVER));
        chk("game_over_after_deck", game_over, 1);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1);
        chk("over_ignores_inputs", state, 3'(OVER));
        cyc(1, 0, 0, 0, 0);
        chk("over_restart", state, 3'(WAIT_FLIP));
        chk("over_restart_flags", {6'd0, game_over, turn}, 8'h00);
        deal_timeout(0, 3'(WAIT_FLIP));

        exp_deal(1);
        cyc(0, 0, 1, 0, 0);
        idle(3);
        chk("pre_reset_window", state, 3'(BELL_WIN));
        rst = 1'b1;
        cyc(0, 0, 0, 1, 1);
        rst = 1'b0;
        chk("mid_reset_state", state, 3'(IDLE));
        chk("mid_reset_outputs", {1'b0, deal_en, turn, award_valid, award_player, award_correct, clear_table, game_over}, 8'h00);
        idle(3);
        chk("idle_stays", state, 3'(IDLE));
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
